host_mem_fill_axi: RTL and testbench

Parametrised multi-line host-memory write engine for the AXI-MM PIM tutorial family. Software programs a line-granular base address, a line count and a data seed over a 64-bit AXI-lite MMIO port, then starts the engine. The engine writes a deterministic pattern to host memory using multi-beat bursts, with address and data channels running concurrently and a bounded number of bursts outstanding. It tracks write responses and reports done/busy/count in a status CSR. It sits between the PIM MMIO and host-memory AXI ports, in place of a single-line writer.

---
 rtl/host_mem_fill_axi.sv | 258 +++++++++++++++++++++++++
 tb/tb_host_mem_fill_axi.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_mem_fill_axi.sv
// Multi-line host-memory fill engine: MMIO-programmed, pipelined AW/W bursts.
// Optional HOST_FILL_BRESP_CHECK_EN flags non-OKAY write responses in STATUS.
module host_mem_fill_axi #(
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 48,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_BURST       = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mmio_arvalid,
    output logic                    mmio_arready,
    input  logic [15:0]             mmio_araddr,
    input  logic [ID_WIDTH-1:0]     mmio_arid,
    output logic                    mmio_rvalid,
    input  logic                    mmio_rready,
    output logic [63:0]             mmio_rdata,
    output logic [ID_WIDTH-1:0]     mmio_rid,
    input  logic                    mmio_awvalid,
    output logic                    mmio_awready,
    input  logic [15:0]             mmio_awaddr,
    input  logic [ID_WIDTH-1:0]     mmio_awid,
    input  logic                    mmio_wvalid,
    output logic                    mmio_wready,
    input  logic [63:0]             mmio_wdata,
    output logic                    mmio_bvalid,
    input  logic                    mmio_bready,
    output logic [ID_WIDTH-1:0]     mmio_bid,
    output logic [1:0]              mmio_bresp,
    output logic                    mem_awvalid,
    input  logic                    mem_awready,
    output logic [ADDR_WIDTH-1:0]   mem_awaddr,
    output logic [7:0]              mem_awlen,
    output logic [2:0]              mem_awsize,
    output logic [ID_WIDTH-1:0]     mem_awid,
    output logic                    mem_wvalid,
    input  logic                    mem_wready,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                    mem_wlast,
    input  logic                    mem_bvalid,
    output logic                    mem_bready,
    input  logic [1:0]              mem_bresp,
    input  logic [ID_WIDTH-1:0]     mem_bid,
    output logic                    mem_arvalid,
    output logic                    mem_rready
);
    localparam int LW    = ADDR_WIDTH - 6;
    localparam int PW    = $clog2(MAX_OUTSTANDING);
    localparam int LANES = DATA_WIDTH / 64;
    localparam logic [63:0] DFH      = 64'h1000_0100_0000_0000;
    localparam logic [63:0] AFU_ID_L = 64'h9f1b_5c3e_a0d2_7e41;
    localparam logic [63:0] AFU_ID_H = 64'h6c4a_d1e8_23b7_4f90;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic          rd_pend;
    logic [3:0]    rd_sel;
    logic [63:0]   rd_mux;
    logic          aw_held, w_held, wr_fire, start_req;
    logic [3:0]    wr_sel;
    logic [63:0]   wr_data;
    logic [LW-1:0] base_q;
    logic [31:0]   num_q, seed_q;

    logic [1:0]    state;
    logic [LW-1:0] cur_line;
    logic [31:0]   remaining, run_seed, w_idx, acked;
    logic [31:0]   burst, to4k;
    logic [7:0]    w_beat;
    logic [PW:0]   aw_ptr, w_ptr, b_ptr, inflight, w_pend;
    logic [7:0]    lenq [MAX_OUTSTANDING];
    logic [7:0]    w_len, b_len;
    logic [32:0]   acked_sum;
    logic          done_q, err_q, busy;
    logic          aw_fire, w_fire, b_fire;

    assign busy         = (state != IDLE);
    assign mmio_arready = !rd_pend && !mmio_rvalid;
    assign mmio_awready = !aw_held && !mmio_bvalid;
    assign mmio_wready  = !w_held && !mmio_bvalid;
    assign mmio_bresp   = 2'b00;
    assign wr_fire      = aw_held && w_held;
    assign start_req    = wr_fire && (wr_sel == 4'd3);

    always_comb begin
        case (rd_sel)
            4'd0:    rd_mux = DFH;
            4'd1:    rd_mux = AFU_ID_L;
            4'd2:    rd_mux = AFU_ID_H;
            4'd5:    rd_mux = {err_q, busy, done_q, 29'd0, acked};
            default: rd_mux = 64'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend     <= 1'b0;
            rd_sel      <= 4'd0;
            mmio_rvalid <= 1'b0;
            mmio_rdata  <= 64'd0;
            mmio_rid    <= '0;
        end else begin
            if (mmio_arvalid && mmio_arready) begin
                rd_pend  <= 1'b1;
                rd_sel   <= mmio_araddr[6:3];
                mmio_rid <= mmio_arid;
            end
            if (rd_pend) begin
                rd_pend     <= 1'b0;
                mmio_rvalid <= 1'b1;
                mmio_rdata  <= rd_mux;
            end
            if (mmio_rvalid && mmio_rready) mmio_rvalid <= 1'b0;
        end
    end

    // Address and data are captured independently; the register commits
    // in the same edge that raises bvalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            wr_sel      <= 4'd0;
            wr_data     <= 64'd0;
            mmio_bvalid <= 1'b0;
            mmio_bid    <= '0;
            base_q      <= '0;
            num_q       <= 32'd0;
            seed_q      <= 32'd0;
        end else begin
            if (mmio_awvalid && mmio_awready) begin
                aw_held  <= 1'b1;
                wr_sel   <= mmio_awaddr[6:3];
                mmio_bid <= mmio_awid;
            end
            if (mmio_wvalid && mmio_wready) begin
                w_held  <= 1'b1;
                wr_data <= mmio_wdata;
            end
            if (wr_fire) begin
                aw_held     <= 1'b0;
                w_held      <= 1'b0;
                mmio_bvalid <= 1'b1;
                case (wr_sel)
                    4'd0:    base_q <= wr_data[LW-1:0];
                    4'd1:    num_q  <= wr_data[31:0];
                    4'd2:    seed_q <= wr_data[31:0];
                    default: ;
                endcase
            end
            if (mmio_bvalid && mmio_bready) mmio_bvalid <= 1'b0;
        end
    end

    // One pointer ring holds every burst length; W and B consume it in order.
    assign inflight = aw_ptr - b_ptr;
    assign w_pend   = aw_ptr - w_ptr;
    assign w_len    = lenq[w_ptr[PW-1:0]];
    assign b_len    = lenq[b_ptr[PW-1:0]];

    always_comb begin
        burst = (remaining < 32'(MAX_BURST)) ? remaining : 32'(MAX_BURST);
        to4k  = 32'd64 - {26'd0, cur_line[5:0]};
        if (to4k < burst) burst = to4k;
    end

    assign mem_awvalid = (state == RUN) &&
                         (inflight < (PW+1)'(MAX_OUTSTANDING));
    assign mem_awaddr  = {cur_line, 6'd0};
    assign mem_awlen   = 8'(burst - 32'd1);
    assign mem_awsize  = 3'b110;
    assign mem_awid    = '0;
    assign mem_wvalid  = (w_pend != '0);
    assign mem_wlast   = (w_beat == w_len);
    assign mem_wstrb   = '1;
    assign mem_bready  = 1'b1;
    assign mem_arvalid = 1'b0;
    assign mem_rready  = 1'b1;
    assign aw_fire     = mem_awvalid && mem_awready;
    assign w_fire      = mem_wvalid && mem_wready;
    assign b_fire      = mem_bvalid && (inflight != '0);
    assign acked_sum   = {1'b0, acked} + {25'd0, b_len} + 33'd1;

    always_comb begin
        mem_wdata = '0;
        for (int k = 0; k < LANES; k++)
            mem_wdata[k*64 +: 64] = {run_seed + w_idx, 32'(k)};
    end

    always_ff @(posedge clk) begin
        if (aw_fire) lenq[aw_ptr[PW-1:0]] <= mem_awlen;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur_line  <= '0;
            remaining <= 32'd0;
            run_seed  <= 32'd0;
            w_idx     <= 32'd0;
            w_beat    <= 8'd0;
            aw_ptr    <= '0;
            w_ptr     <= '0;
            b_ptr     <= '0;
            acked     <= 32'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (aw_fire) begin
                aw_ptr    <= aw_ptr + 1'b1;
                cur_line  <= cur_line + LW'(burst);
                remaining <= remaining - burst;
                if (remaining == burst) state <= DRAIN;
            end
            if (w_fire) begin
                w_idx <= w_idx + 32'd1;
                if (mem_wlast) begin
                    w_beat <= 8'd0;
                    w_ptr  <= w_ptr + 1'b1;
                end else begin
                    w_beat <= w_beat + 8'd1;
                end
            end
            if (b_fire) begin
                b_ptr <= b_ptr + 1'b1;
                acked <= acked_sum[32] ? 32'hFFFF_FFFF : acked_sum[31:0];
`ifdef HOST_FILL_BRESP_CHECK_EN
                if (mem_bresp != 2'b00) err_q <= 1'b1;
`endif
            end
            if (state == DRAIN && inflight == '0 && w_pend == '0) begin
                state  <= IDLE;
                done_q <= 1'b1;
            end
            if (start_req && state == IDLE) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
                acked  <= 32'd0;
                w_idx  <= 32'd0;
                if (num_q == 32'd0) begin
                    done_q <= 1'b1;
                end else begin
                    state     <= RUN;
                    cur_line  <= base_q;
                    remaining <= num_q;
                    run_seed  <= seed_q;
                end
            end
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, mmio_araddr, mmio_awaddr, wr_data,
                         mem_bid, mem_bresp};
endmodule

// File: tb/tb_host_mem_fill_axi.sv
// Scoreboard bench for host_mem_fill_axi: host-memory slave model plus
// MMIO driver; expected AW/W traffic is queued when each run is programmed.
module tb_host_mem_fill_axi;
    localparam int DW = 512;
    localparam int AW = 48;
    localparam int IW = 4;
    localparam logic [63:0] DFH_EXP  = 64'h1000_0100_0000_0000;
    localparam logic [63:0] IDL_EXP  = 64'h9f1b_5c3e_a0d2_7e41;
    localparam logic [63:0] IDH_EXP  = 64'h6c4a_d1e8_23b7_4f90;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          mmio_arvalid, mmio_arready;
    logic [15:0]   mmio_araddr;
    logic [IW-1:0] mmio_arid;
    logic          mmio_rvalid, mmio_rready;
    logic [63:0]   mmio_rdata;
    logic [IW-1:0] mmio_rid;
    logic          mmio_awvalid, mmio_awready;
    logic [15:0]   mmio_awaddr;
    logic [IW-1:0] mmio_awid;
    logic          mmio_wvalid, mmio_wready;
    logic [63:0]   mmio_wdata;
    logic          mmio_bvalid, mmio_bready;
    logic [IW-1:0] mmio_bid;
    logic [1:0]    mmio_bresp;
    logic          mem_awvalid, mem_awready;
    logic [AW-1:0] mem_awaddr;
    logic [7:0]    mem_awlen;
    logic [2:0]    mem_awsize;
    logic [IW-1:0] mem_awid;
    logic          mem_wvalid, mem_wready, mem_wlast;
    logic [DW-1:0] mem_wdata;
    logic [DW/8-1:0] mem_wstrb;
    logic          mem_bvalid, mem_bready;
    logic [1:0]    mem_bresp;
    logic [IW-1:0] mem_bid;
    logic          mem_arvalid, mem_rready;

    int checks = 0;
    int errors = 0;
    bit b_hold = 1'b0;
    bit rand_wready = 1'b0;
    int err_burst = -1;
    int b_num = 0;

    logic [AW-1:0] exp_aw_addr[$];
    logic [7:0]    exp_aw_len[$];
    logic [DW-1:0] exp_w_data[$];
    bit            exp_w_last[$];
    logic [AW-1:0] obs_aw_addr[$];
    logic [7:0]    obs_aw_len[$];
    logic [DW-1:0] obs_w[$];
    int            b_pend[$];

    host_mem_fill_axi dut (
        .clk(clk), .reset(reset),
        .mmio_arvalid(mmio_arvalid), .mmio_arready(mmio_arready),
        .mmio_araddr(mmio_araddr), .mmio_arid(mmio_arid),
        .mmio_rvalid(mmio_rvalid), .mmio_rready(mmio_rready),
        .mmio_rdata(mmio_rdata), .mmio_rid(mmio_rid),
        .mmio_awvalid(mmio_awvalid), .mmio_awready(mmio_awready),
        .mmio_awaddr(mmio_awaddr), .mmio_awid(mmio_awid),
        .mmio_wvalid(mmio_wvalid), .mmio_wready(mmio_wready),
        .mmio_wdata(mmio_wdata),
        .mmio_bvalid(mmio_bvalid), .mmio_bready(mmio_bready),
        .mmio_bid(mmio_bid), .mmio_bresp(mmio_bresp),
        .mem_awvalid(mem_awvalid), .mem_awready(mem_awready),
        .mem_awaddr(mem_awaddr), .mem_awlen(mem_awlen),
        .mem_awsize(mem_awsize), .mem_awid(mem_awid),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wlast(mem_wlast),
        .mem_bvalid(mem_bvalid), .mem_bready(mem_bready),
        .mem_bresp(mem_bresp), .mem_bid(mem_bid),
        .mem_arvalid(mem_arvalid), .mem_rready(mem_rready)
    );

    function automatic logic [DW-1:0] exp_line(input logic [31:0] seed,
                                               input logic [31:0] idx);
        logic [DW-1:0] d;
        logic [31:0] hi;
        hi = seed + idx;
        for (int k = 0; k < DW/64; k++) d[k*64 +: 64] = {hi, 32'(k)};
        return d;
    endfunction

    // Host-memory monitor: pops the scoreboard on every AW and W handshake.
    initial forever begin
        logic [AW-1:0] ea;
        logic [7:0] el;
        logic [DW-1:0] ed;
        bit elast;
        @(negedge clk);
        if (!reset && mem_awvalid && mem_awready) begin
            obs_aw_addr.push_back(mem_awaddr);
            obs_aw_len.push_back(mem_awlen);
            checks++;
            if (exp_aw_addr.size() == 0) begin
                errors++;
                $display("FAIL aw_unexpected: got addr=%h len=%0d, required no burst",
                         mem_awaddr, mem_awlen);
            end else begin
                ea = exp_aw_addr.pop_front();
                el = exp_aw_len.pop_front();
                if (mem_awaddr !== ea || mem_awlen !== el || mem_awsize !== 3'b110) begin
                    errors++;
                    $display("FAIL aw_burst: got addr=%h len=%0d size=%b, required addr=%h len=%0d size=110",
                             mem_awaddr, mem_awlen, mem_awsize, ea, el);
                end
            end
        end
        if (!reset && mem_wvalid && mem_wready) begin
            obs_w.push_back(mem_wdata);
            if (mem_wlast) b_pend.push_back(1);
            checks++;
            if (exp_w_data.size() == 0) begin
                errors++;
                $display("FAIL w_unexpected: got lane0=%h, required no beat",
                         mem_wdata[63:0]);
            end else begin
                ed = exp_w_data.pop_front();
                elast = exp_w_last.pop_front();
                if (mem_wdata !== ed || mem_wlast !== elast || mem_wstrb !== '1) begin
                    errors++;
                    $display("FAIL w_beat: got lane0=%h last=%b, required lane0=%h last=%b",
                             mem_wdata[63:0], mem_wlast, ed[63:0], elast);
                end
            end
        end
    end

    initial begin
        mem_bvalid = 1'b0;
        mem_bresp  = 2'b00;
        mem_bid    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_bvalid && mem_bready) mem_bvalid = 1'b0;
            if (!mem_bvalid && !b_hold && b_pend.size() > 0) begin
                void'(b_pend.pop_front());
                mem_bresp  = (b_num == err_burst) ? 2'b10 : 2'b00;
                b_num++;
                mem_bvalid = 1'b1;
            end
        end
    end

    initial begin
        mem_awready = 1'b1;
        mem_wready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            mem_wready = rand_wready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic mmio_write(input logic [15:0] a, input logic [63:0] d);
        int n;
        bit aw_hs, w_hs;
        @(posedge clk);
        #1;
        mmio_awaddr  = a;
        mmio_awvalid = 1'b1;
        mmio_wdata   = d;
        mmio_wvalid  = 1'b1;
        n = 0;
        while ((mmio_awvalid || mmio_wvalid) && n < 50) begin
            @(negedge clk);
            aw_hs = mmio_awvalid && mmio_awready;
            w_hs  = mmio_wvalid && mmio_wready;
            @(posedge clk);
            #1;
            if (aw_hs) mmio_awvalid = 1'b0;
            if (w_hs) mmio_wvalid = 1'b0;
            n++;
        end
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (mmio_bvalid) break;
            n++;
        end
        if (n >= 50 || mmio_awvalid || mmio_wvalid) begin
            checks++;
            errors++;
            $display("FAIL mmio_write_timeout: addr=%h got no bvalid, required bvalid within 50 cycles", a);
            mmio_awvalid = 1'b0;
            mmio_wvalid  = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mmio_read(input logic [15:0] a, output logic [63:0] d,
                             output int lat);
        int n;
        @(posedge clk);
        #1;
        mmio_araddr  = a;
        mmio_arvalid = 1'b1;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (mmio_arready) break;
            n++;
        end
        @(posedge clk);
        #1;
        mmio_arvalid = 1'b0;
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (mmio_rvalid) break;
        end
        d = mmio_rdata;
        if (n >= 50 || lat >= 50) begin
            checks++;
            errors++;
            $display("FAIL mmio_read_timeout: addr=%h got no rvalid, required rvalid within 50 cycles", a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output logic [63:0] st);
        int lat;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            mmio_read(16'h28, st, lat);
            if (st[61]) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_done: status=%h, required done=1 within 300 polls", st);
        end
    endtask

    task automatic start_run(input logic [63:0] base, input int unsigned n,
                             input logic [31:0] seed);
        logic [AW-7:0] line;
        int unsigned rem, b, t;
        logic [31:0] idx;
        obs_aw_addr.delete();
        obs_aw_len.delete();
        obs_w.delete();
        b_num = 0;
        line = base[AW-7:0];
        rem = n;
        idx = 0;
        while (rem > 0) begin
            b = (rem < 4) ? rem : 4;
            t = 64 - int'(line[5:0]);
            if (t < b) b = t;
            exp_aw_addr.push_back({line, 6'd0});
            exp_aw_len.push_back(8'(b - 1));
            for (int j = 0; j < int'(b); j++) begin
                exp_w_data.push_back(exp_line(seed, idx));
                exp_w_last.push_back(j == int'(b) - 1);
                idx++;
                line++;
            end
            rem -= b;
        end
        mmio_write(16'h00, base);
        mmio_write(16'h08, 64'(n));
        mmio_write(16'h10, 64'(seed));
        mmio_write(16'h18, 64'd0);
    endtask

    task automatic check_drained(input string tag);
        checks++;
        if (exp_aw_addr.size() != 0 || exp_w_data.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: got %0d aw and %0d w outstanding, required 0 and 0",
                     tag, exp_aw_addr.size(), exp_w_data.size());
        end
    endtask

    task automatic test_reset();
        logic [63:0] d;
        int lat;
        logic [63:0] want [4];
        logic [15:0] addr [4];
        want = '{DFH_EXP, IDL_EXP, IDH_EXP, 64'd0};
        addr = '{16'h00, 16'h08, 16'h10, 16'h28};
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({mmio_arready, mmio_awready, mmio_wready, mmio_rvalid, mmio_bvalid,
             mem_awvalid, mem_wvalid, mem_arvalid, mem_rready, mem_bready}
            !== 10'b1110000011) begin
            errors++;
            $display("FAIL reset_outputs: got ar/aw/w rdy=%b%b%b rv=%b bv=%b awv=%b wv=%b arv=%b rrdy=%b brdy=%b, required 1110000011",
                     mmio_arready, mmio_awready, mmio_wready, mmio_rvalid, mmio_bvalid,
                     mem_awvalid, mem_wvalid, mem_arvalid, mem_rready, mem_bready);
        end
        for (int i = 0; i < 4; i++) begin
            mmio_read(addr[i], d, lat);
            checks++;
            if (d !== want[i]) begin
                errors++;
                $display("FAIL reset_read: addr=%h got %h, required %h", addr[i], d, want[i]);
            end
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL read_latency: addr=%h got %0d, required 2", addr[i], lat);
            end
        end
    endtask

    task automatic test_fill();
        logic [63:0] st;
        logic [DW-1:0] beat;
        start_run(64'h1000, 10, 32'h100);
        wait_done(st);
        checks++;
        if (obs_aw_addr.size() != 3 ||
            obs_aw_addr[0] !== 48'h40000 || obs_aw_len[0] !== 8'd3 ||
            obs_aw_addr[1] !== 48'h40100 || obs_aw_len[1] !== 8'd3 ||
            obs_aw_addr[2] !== 48'h40200 || obs_aw_len[2] !== 8'd1) begin
            errors++;
            $display("FAIL fill_bursts: got %0d bursts first=%h/%0d, required 3 bursts 40000/3 40100/3 40200/1",
                     obs_aw_addr.size(), obs_aw_addr[0], obs_aw_len[0]);
        end
        beat = obs_w[9];
        checks++;
        if (beat[191:128] !== 64'h00000109_00000002) begin
            errors++;
            $display("FAIL fill_line9_lane2: got %h, required 0000010900000002", beat[191:128]);
        end
        checks++;
        if (st !== 64'h2000_0000_0000_000A) begin
            errors++;
            $display("FAIL fill_status: got %h, required 200000000000000a", st);
        end
        check_drained("fill");
    endtask

    task automatic test_4k_boundary();
        logic [63:0] st;
        start_run(64'h3E, 5, 32'hABCD);
        wait_done(st);
        checks++;
        if (obs_aw_addr.size() != 2 ||
            obs_aw_addr[0] !== 48'hF80 || obs_aw_len[0] !== 8'd1 ||
            obs_aw_addr[0] + 48'((obs_aw_len[0] + 1) * 64) - 48'd1 !== 48'hFFF ||
            obs_aw_addr[1] !== 48'h1000 || obs_aw_len[1] !== 8'd2) begin
            errors++;
            $display("FAIL 4k_bursts: got %0d bursts %h/%0d %h/%0d, required f80/1 1000/2",
                     obs_aw_addr.size(), obs_aw_addr[0], obs_aw_len[0],
                     obs_aw_addr[1], obs_aw_len[1]);
        end
        checks++;
        if (st[61] !== 1'b1 || st[31:0] !== 32'd5) begin
            errors++;
            $display("FAIL 4k_status: got %h, required done=1 count=5", st);
        end
        check_drained("4k");
    endtask

    task automatic test_b_backpressure();
        logic [63:0] st;
        int lat;
        b_hold = 1'b1;
        rand_wready = 1'b1;
        start_run(64'h2000, 64, 32'h5555_0000);
        repeat (100) @(posedge clk);
        checks++;
        if (obs_aw_addr.size() != 8) begin
            errors++;
            $display("FAIL bstall_aw_count: got %0d, required 8", obs_aw_addr.size());
        end
        mmio_read(16'h28, st, lat);
        checks++;
        if (st[62] !== 1'b1 || st[61] !== 1'b0 || st[31:0] !== 32'd0) begin
            errors++;
            $display("FAIL bstall_status: got %h, required busy=1 done=0 count=0", st);
        end
        b_hold = 1'b0;
        wait_done(st);
        rand_wready = 1'b0;
        checks++;
        if (st[62] !== 1'b0 || st[31:0] !== 32'd64 || obs_aw_addr.size() != 16) begin
            errors++;
            $display("FAIL bstall_release: status=%h bursts=%0d, required busy=0 count=64 bursts=16",
                     st, obs_aw_addr.size());
        end
        check_drained("bstall");
    endtask

    task automatic test_bresp_error();
        logic [63:0] st;
        logic exp_err;
`ifdef HOST_FILL_BRESP_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        err_burst = 1;
        start_run(64'h800, 12, 32'd7);
        wait_done(st);
        err_burst = -1;
        checks++;
        if (st[63] !== exp_err || st[61] !== 1'b1 || st[31:0] !== 32'd12) begin
            errors++;
            $display("FAIL bresp_error: got %h, required error=%b done=1 count=12", st, exp_err);
        end
        check_drained("bresp");
    endtask

    task automatic test_start_zero();
        logic [63:0] st;
        int lat;
        start_run(64'h40, 0, 32'd1);
        mmio_read(16'h28, st, lat);
        checks++;
        if (st !== 64'h2000_0000_0000_0000) begin
            errors++;
            $display("FAIL zero_status: got %h, required 2000000000000000", st);
        end
        repeat (10) @(posedge clk);
        checks++;
        if (obs_aw_addr.size() != 0) begin
            errors++;
            $display("FAIL zero_no_aw: got %0d bursts, required 0", obs_aw_addr.size());
        end
    endtask

    task automatic test_start_while_busy();
        logic [63:0] st;
        int lat;
        b_hold = 1'b1;
        start_run(64'h500, 20, 32'h77);
        repeat (20) @(posedge clk);
        mmio_write(16'h08, 64'd3);
        mmio_write(16'h10, 64'hDEAD);
        mmio_write(16'h18, 64'd0);
        mmio_read(16'h28, st, lat);
        checks++;
        if (st[62] !== 1'b1) begin
            errors++;
            $display("FAIL busy_restart_status: got %h, required busy=1", st);
        end
        b_hold = 1'b0;
        wait_done(st);
        repeat (20) @(posedge clk);
        checks++;
        if (st[31:0] !== 32'd20 || obs_aw_addr.size() != 5) begin
            errors++;
            $display("FAIL busy_restart: count=%0d bursts=%0d, required count=20 bursts=5",
                     st[31:0], obs_aw_addr.size());
        end
        check_drained("busy");
    endtask

    initial begin
        reset = 1'b1;
        mmio_arvalid = 1'b0;
        mmio_araddr  = '0;
        mmio_arid    = '0;
        mmio_rready  = 1'b1;
        mmio_awvalid = 1'b0;
        mmio_awaddr  = '0;
        mmio_awid    = '0;
        mmio_wvalid  = 1'b0;
        mmio_wdata   = '0;
        mmio_bready  = 1'b1;
        test_reset();
        test_fill();
        test_4k_boundary();
        test_b_backpressure();
        test_bresp_error();
        test_start_zero();
        test_start_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end
endmodule
